// File: rtl/if_id_buffer_pkg.sv
// Shared types and constants for the fetch/decode instruction buffer.
package if_id_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instruction;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch/decode side signals of the instruction buffer.
// master: the environment (fetch + decode + branch unit); slave: the buffer.
interface if_id_buffer_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
);
    logic                     flush;
    logic                     in_valid;
    logic [WIDTH-1:0]         in_pc;
    logic [WIDTH-1:0]         in_instruction;
    logic                     in_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_pc;
    logic [WIDTH-1:0]         out_instruction;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        output flush, in_valid, in_pc, in_instruction, out_ready,
        input  in_ready, out_valid, out_pc, out_instruction, level
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instruction, out_ready,
        output in_ready, out_valid, out_pc, out_instruction, level
    );
endinterface

// File: rtl/if_id_buffer_ram.sv
// Entry storage for the instruction buffer: synchronous write,
// synchronous clear, asynchronous read.
module if_id_buffer_ram #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wr_pc,
    input  logic [WIDTH-1:0] i_wr_instr,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rd_pc,
    output logic [WIDTH-1:0] o_rd_instr
);

    logic [WIDTH-1:0] r_pc    [DEPTH];
    logic [WIDTH-1:0] r_instr [DEPTH];

    // Clear every entry on reset, otherwise write one entry per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
            end
        end else if (i_we) begin
            r_pc[i_waddr]    <= i_wr_pc;
            r_instr[i_waddr] <= i_wr_instr;
        end
    end

    assign o_rd_pc    = r_pc[i_raddr];
    assign o_rd_instr = r_instr[i_raddr];

endmodule

// File: rtl/if_id_buffer.sv
// Instruction buffer between fetch and decode.
// Optional performance counters are enabled with `define IF_ID_BUFFER_PERF_EN.
module if_id_buffer
    import if_id_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    if_id_buffer_if.slave      bus
`ifdef IF_ID_BUFFER_PERF_EN
    ,
    output logic [31:0]        full_cycles,
    output logic [15:0]        flush_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_we;
    logic [WIDTH-1:0] w_rd_pc;
    logic [WIDTH-1:0] w_rd_instr;

    // Handshake flags come only from the registered count; no pass-through when full.
    assign w_in_ready  = (r_count != CNT_FULL);
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;
    assign w_we        = w_push & ~bus.flush;

    if_id_buffer_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_we),
        .i_waddr    (r_wr_ptr),
        .i_wr_pc    (bus.in_pc),
        .i_wr_instr (bus.in_instruction),
        .i_raddr    (r_rd_ptr),
        .o_rd_pc    (w_rd_pc),
        .o_rd_instr (w_rd_instr)
    );

    // Pointer and occupancy update: reset, then flush, then push/pop.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Empty buffer presents a NOP to decode.
    always_comb begin
        bus.in_ready        = w_in_ready;
        bus.out_valid       = w_out_valid;
        bus.level           = r_count;
        bus.out_pc          = '0;
        bus.out_instruction = WIDTH'(NOP_INSTR);
        if (w_out_valid) begin
            bus.out_pc          = w_rd_pc;
            bus.out_instruction = w_rd_instr;
        end
    end

`ifdef IF_ID_BUFFER_PERF_EN
    logic [31:0] r_full_cycles;
    logic [15:0] r_flush_count;

    // Saturating counters of fetch stalls on full and of flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full_cycles <= '0;
            r_flush_count <= '0;
        end else begin
            if (!w_in_ready && bus.in_valid && (r_full_cycles != '1)) begin
                r_full_cycles <= r_full_cycles + 32'd1;
            end
            if (bus.flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign full_cycles = r_full_cycles;
    assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_if_id_buffer;
    import if_id_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_id_buffer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

`ifdef IF_ID_BUFFER_PERF_EN
    logic [31:0] full_cycles;
    logic [15:0] flush_count;
`endif

    if_id_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IF_ID_BUFFER_PERF_EN
        ,
        .full_cycles (full_cycles),
        .flush_count (flush_count)
`endif
    );

    typedef struct {
        logic        r;
        logic        f;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        ordy;
        logic        exp_rdy;
        logic        exp_vld;
        logic [31:0] exp_pc;
        logic [31:0] exp_ins;
        logic [31:0] exp_lvl;
    } vec_t;

    vec_t         tbl [11];
    if_id_entry_t mq[$];
    logic [31:0]  sent[$];
    logic [31:0]  got[$];
    logic [31:0]  m_full;
    logic [15:0]  m_flush;
    int           n_vec = 0;
    int           n_bad = 0;

    function automatic vec_t mk(logic r, logic f, logic iv, logic [31:0] pc, logic [31:0] ins,
                                logic ordy, logic er, logic ev, logic [31:0] ep,
                                logic [31:0] ei, logic [31:0] el);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.pc = pc; v.ins = ins; v.ordy = ordy;
        v.exp_rdy = er; v.exp_vld = ev; v.exp_pc = ep; v.exp_ins = ei; v.exp_lvl = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_model(input string tag);
        logic [31:0] ep;
        logic [31:0] ei;
        ep = (mq.size() != 0) ? mq[0].pc : 32'h0;
        ei = (mq.size() != 0) ? mq[0].instruction : 32'h0;
        chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(mq.size() != DEPTH));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mq.size() != 0));
        chk({tag, ".out_pc"},    bus.out_pc,          ep);
        chk({tag, ".out_instr"}, bus.out_instruction, ei);
        chk({tag, ".level"},     32'(bus.level),     32'(mq.size()));
`ifdef IF_ID_BUFFER_PERF_EN
        chk({tag, ".full_cycles"}, full_cycles,        m_full);
        chk({tag, ".flush_count"}, 32'(flush_count),  32'(m_flush));
`endif
    endtask

    // One clock: drive inputs, advance the model, clock the DUT, compare.
    task automatic cycle(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                         input logic [31:0] ins, input logic ordy, input string tag);
        bit           m_push;
        bit           m_pop;
        if_id_entry_t e;
        rst = r; bus.flush = f; bus.in_valid = iv; bus.in_pc = pc;
        bus.in_instruction = ins; bus.out_ready = ordy;
        #3;
        m_push = iv && (mq.size() < DEPTH);
        m_pop  = (mq.size() > 0) && ordy;
        if (!r && !f && bus.out_valid === 1'b1 && ordy) got.push_back(bus.out_pc);
        if (r) begin
            mq.delete();
            m_full  = '0;
            m_flush = '0;
        end else begin
            if (mq.size() == DEPTH && iv && m_full != 32'hFFFF_FFFF) m_full++;
            if (f && m_flush != 16'hFFFF) m_flush++;
            if (f) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    e.pc = pc;
                    e.instruction = ins;
                    mq.push_back(e);
                    sent.push_back(pc);
                end
            end
        end
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    initial begin
        m_full  = '0;
        m_flush = '0;

        tbl[0]  = mk(1, 0, 0, 32'd0,  32'h0,         0, 1, 0, 32'd0,  32'h0,         0);
        tbl[1]  = mk(1, 0, 0, 32'd0,  32'h0,         0, 1, 0, 32'd0,  32'h0,         0);
        tbl[2]  = mk(0, 0, 1, 32'd4,  32'hA000_0000, 0, 1, 1, 32'd4,  32'hA000_0000, 1);
        tbl[3]  = mk(0, 0, 1, 32'd8,  32'hA000_0001, 0, 1, 1, 32'd4,  32'hA000_0000, 2);
        tbl[4]  = mk(0, 0, 1, 32'd12, 32'hA000_0002, 0, 1, 1, 32'd4,  32'hA000_0000, 3);
        tbl[5]  = mk(0, 0, 1, 32'd16, 32'hA000_0003, 0, 0, 1, 32'd4,  32'hA000_0000, 4);
        tbl[6]  = mk(0, 0, 1, 32'd20, 32'hA000_0004, 0, 0, 1, 32'd4,  32'hA000_0000, 4);
        tbl[7]  = mk(0, 0, 0, 32'd0,  32'h0,         1, 1, 1, 32'd8,  32'hA000_0001, 3);
        tbl[8]  = mk(0, 0, 0, 32'd0,  32'h0,         1, 1, 1, 32'd12, 32'hA000_0002, 2);
        tbl[9]  = mk(0, 0, 0, 32'd0,  32'h0,         1, 1, 1, 32'd16, 32'hA000_0003, 1);
        tbl[10] = mk(0, 0, 0, 32'd0,  32'h0,         1, 1, 0, 32'd0,  32'h0,         0);

        // Reset, fill to full, rejected fifth push, in-order drain.
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].pc, tbl[i].ins, tbl[i].ordy,
                  $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.in_ready", i),  32'(bus.in_ready),  32'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d.out_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_vld));
            chk($sformatf("tbl%0d.out_pc", i),    bus.out_pc,          tbl[i].exp_pc);
            chk($sformatf("tbl%0d.out_instr", i), bus.out_instruction, tbl[i].exp_ins);
            chk($sformatf("tbl%0d.level", i),     32'(bus.level),     tbl[i].exp_lvl);
        end

        // Streaming from empty: one in, one out per cycle, level steady at 1.
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1, 32'd200 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1, "stream");
            chk("stream.level", 32'(bus.level), 32'd1);
            chk("stream.pc", bus.out_pc, 32'd200 + 32'(4 * i));
        end

        // Flush with level 3 drops contents and the same-cycle push.
        cycle(0, 0, 1, 32'd300, 32'hC000_0000, 0, "flush_pre");
        cycle(0, 0, 1, 32'd304, 32'hC000_0001, 0, "flush_pre");
        chk("flush_pre.level", 32'(bus.level), 32'd3);
        cycle(0, 1, 1, 32'd40, 32'hC000_0040, 1, "flush");
        chk("flush.level", 32'(bus.level), 32'd0);
        chk("flush.out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush.in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 32'd0, 32'h0, 1, "flush_post");
            chk("flush_post.out_valid", 32'(bus.out_valid), 32'd0);
        end

        // Wrap-around: 11 pushes with staggered pops, order must be preserved.
        sent.delete();
        got.delete();
        for (int i = 0; i < 80 && sent.size() < 11; i++) begin
            cycle(0, 0, (i % 4) != 3, 32'h1000 + 32'(4 * i), 32'hD000_0000 + 32'(i),
                  (i % 3) != 0, "wrap");
        end
        chk("wrap.pushes", 32'(sent.size()), 32'd11);
        for (int i = 0; i < 20 && mq.size() != 0; i++) begin
            cycle(0, 0, 0, 32'd0, 32'h0, 1, "wrap_drain");
        end
        chk("wrap.popped", 32'(got.size()), 32'(sent.size()));
        for (int i = 0; i < sent.size() && i < got.size(); i++) begin
            chk($sformatf("wrap.order%0d", i), got[i], sent[i]);
        end

        // Reset mid-operation clears contents and counters.
        cycle(0, 0, 1, 32'd500, 32'hE000_0000, 0, "rstmid_pre");
        cycle(0, 0, 1, 32'd504, 32'hE000_0001, 0, "rstmid_pre");
        chk("rstmid_pre.level", 32'(bus.level), 32'd2);
        cycle(1, 0, 1, 32'd508, 32'hE000_0002, 0, "rstmid");
        chk("rstmid.level", 32'(bus.level), 32'd0);
        chk("rstmid.out_instr", bus.out_instruction, 32'h0);
`ifdef IF_ID_BUFFER_PERF_EN
        chk("rstmid.full_cycles", full_cycles, 32'd0);
        chk("rstmid.flush_count", 32'(flush_count), 32'd0);
`endif

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(3) != 0,
                  $urandom, $urandom, $urandom_range(2) != 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Instruction buffer between the fetch stage and the decode stage. It stores fetched {pc, instruction} pairs in a small FIFO so that decode stalls do not stop fetch immediately. It backpressures fetch when full. It discards all wrong-path entries when a branch is taken.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- WIDTH, 32: width of the pc and instruction fields.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  branch taken in EXE; discard all contents and the current input.
- in_valid  in  1  fetch presents a valid instruction.
- in_pc  in  WIDTH  pc+4 of the fetched instruction, as produced by fetch.
- in_instruction  in  WIDTH  fetched instruction word.
- in_ready  out  1  buffer accepts input; top level drives fetch freeze = !in_ready.
- out_valid  out  1  head entry is valid for decode.
- out_pc  out  WIDTH  head pc.
- out_instruction  out  WIDTH  head instruction; NOP when empty.
- out_ready  in  1  decode consumes the head (the inverse of the hazard freeze).
- level  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Circular storage of DEPTH entries with rd_ptr, wr_ptr ($clog2(DEPTH) bits, natural wrap) and count ($clog2(DEPTH)+1 bits).
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). There is no pass-through when full: a pop while full does not allow a push in the same cycle.
- out_valid = (count != 0).
- out_pc and out_instruction = entry[rd_ptr] when out_valid, else 0 (NOP).
- level = count.
- Priority at each edge, highest first:
  1. rst: pointers and count go to 0, and all entries are zeroed.
  2. flush: pointers and count go to 0. A same-cycle push is dropped and a same-cycle pop is ignored. Entry contents need not be cleared.
  3. Push only: write entry[wr_ptr], wr_ptr+1, count+1.
  4. Pop only: rd_ptr+1, count-1.
  5. Push and pop (possible only when 0 < count < DEPTH): write and advance both pointers; count is unchanged.
- Pushing when empty is legal. The entry appears at the output after the edge; there is no combinational bypass.
- Decode never receives an entry accepted in or before a flush cycle.

## Timing
- Reset values: in_ready=1, out_valid=0, out_pc=0, out_instruction=0, level=0.
- Latency from input to output is 1 cycle: push at edge N gives out_valid=1 after edge N.
- in_ready and out_valid depend only on registered count. There is no combinational path from inputs to outputs except the output mux driven by rd_ptr.
- Full: in_ready drops in the cycle after the DEPTH-th push. It rises again in the cycle after the first pop.
- Empty: out_valid drops in the cycle after the last pop.
- Flush and reset take effect at the edge on which they are sampled. The buffer is empty with in_ready=1 in the following cycle.
- Reset asserted mid-stream behaves as flush, and additionally clears entries and the performance counters.

## Configuration
- IF_ID_BUFFER_PERF_EN defined:
  - Adds output full_cycles [31:0], which counts cycles with count==DEPTH & in_valid.
  - Adds output flush_count [15:0], which counts cycles with flush=1.
  - Both counters saturate at all-ones and are cleared only by rst.
- IF_ID_BUFFER_PERF_EN undefined: neither port nor its logic exists. All other behaviour is identical.

## Structure
- Shared package if_id_pkg holds:
  - INSTR_W=32 and NOP_INSTR=32'h0.
  - Typedef if_id_entry_t with fields pc and instruction.
- One sub-module, if_id_buffer_ram, holds the storage: DEPTH x entry registers with synchronous write, synchronous reset-to-zero and asynchronous read at rd_ptr.
- Pointer, count and handshake logic stay in if_id_buffer.

## Test plan
- Reset then idle: hold rst for 2 cycles → in_ready=1, out_valid=0, out_instruction=0, level=0.
- Fill to full (DEPTH=4, out_ready=0):
  - Push pc=4,8,12,16 with instr=A0..A3 → level=4 and in_ready=0.
  - A 5th in_valid with pc=20 is not stored.
  - Then out_ready=1 → A0..A3 emerge in order, one per cycle, and out_valid=0 afterwards.
- Streaming: in_valid=1 and out_ready=1 on every cycle starting from empty → after 1 cycle of latency, one instruction per cycle, level stays 1, nothing is dropped.
- Flush: with level=3, assert flush together with in_valid (pc=40) and out_ready=1 → next cycle level=0, out_valid=0, and pc=40 never appears.
- Wrap-around: run 11 push/pop pairs with a staggered pattern so the pointers wrap at least twice → the output order matches the input order exactly.
- Reset mid-operation: with level=2, assert rst while in_valid=1 → next cycle level=0 and out_instruction=0. With IF_ID_BUFFER_PERF_EN defined, full_cycles=0 and flush_count=0.
